// File: rtl/ldpc_enc_pkg.sv
// Shared types and constants for the LDPC encoder frame sequencer.
// Holds the sequencer state encoding and the frame geometry.
package ldpc_enc_pkg;

   localparam int unsigned K_BITS   = 4320;  // information bits per frame
   localparam int unsigned GROUP    = 360;   // parallelism / parity bits per frame
   localparam int unsigned N_GROUPS = 12;    // K_BITS / GROUP
   localparam int unsigned CNT_W    = 13;    // enc_counter width
   localparam int unsigned ADDR_W   = 9;     // enc_out_addr width
   localparam int unsigned CLR_CYC  = 3;     // encoder clear cycles before a frame
   localparam int unsigned CLR_W    = 2;     // clear counter width

   typedef enum logic [2:0] {
      CLEAR  = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      PARITY = 3'd3,
      TAIL   = 3'd4
   } state_t;

endpackage

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer for the 360-bit-parallel LDPC parity encoder.
// Accepts K_BITS information bits over valid/ready, drives the encoder's
// clear/din/counter/address/check controls and serialises the parity bits.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_bit, in_ready information bit handshake
//   abort                      synchronous frame abort
//   enc_rst_n                  encoder clear (active-low)
//   enc_din_valid, enc_din     encoder data input
//   enc_counter                index of the bit on enc_din
//   enc_out_addr               parity bit select (GROUP-1 down to 0)
//   enc_check                  encoder data_valid_check
//   enc_dout                   encoder parity bit, 1 cycle after enc_out_addr
//   out_valid, out_bit         serial codeword output
//   out_sop, out_last          first / last codeword bit markers
//   busy                       high outside CLEAR
//
// Build option: LDPC_ENC_CTRL_SYS_EN echoes the information bits ahead of
// the parity (systematic codeword); otherwise only parity bits are emitted.
module ldpc_enc_ctrl
   import ldpc_enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              in_ready,
   input  logic              abort,
   output logic              enc_rst_n,
   output logic              enc_din_valid,
   output logic              enc_din,
   output logic [CNT_W-1:0]  enc_counter,
   output logic [ADDR_W-1:0] enc_out_addr,
   output logic              enc_check,
   input  logic              enc_dout,
   output logic              out_valid,
   output logic              out_bit,
   output logic              out_sop,
   output logic              out_last,
   output logic              busy
);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(K_BITS - 1);
   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(GROUP - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYC - 1);

   state_t              state_q, state_d;
   logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                in_ready_q, in_ready_d;
   logic                enc_run_q, enc_run_d;
   logic                check_q, check_d;
   logic                busy_q, busy_d;
   logic                info_vld_q, info_vld_d;
   logic                info_bit_q, info_bit_d;
   logic                par_vld_q, par_vld_d;
   logic                sop_q, sop_d;
   logic                last_q, last_d;
   logic                hs;

   assign hs = in_valid & in_ready_q;

   // Next state, counters and output staging
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      info_vld_d = 1'b0;
      info_bit_d = 1'b0;
      par_vld_d  = 1'b0;
      sop_d      = 1'b0;
      last_d     = 1'b0;

      case (state_q)
         CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d   = LOAD;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
         end
         LOAD: begin
            if (hs) begin
`ifdef LDPC_ENC_CTRL_SYS_EN
               info_vld_d = 1'b1;
               info_bit_d = in_bit;
               sop_d      = (cnt_q == '0);
`endif
               // Counter holds on the final bit so the encoder sees K_BITS-1 through SETTLE
               if (cnt_q == CNT_LAST) state_d = SETTLE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: state_d = PARITY;
         PARITY: begin
            par_vld_d = 1'b1;
`ifdef LDPC_ENC_CTRL_SYS_EN
            sop_d     = 1'b0;
`else
            sop_d     = (addr_q == ADDR_TOP);
`endif
            last_d    = (addr_q == '0);
            if (addr_q == '0) state_d = TAIL;
            else              addr_d  = addr_q - ADDR_W'(1);
         end
         TAIL:    state_d = CLEAR;
         default: state_d = CLEAR;
      endcase

      // Abort drops any staged output bit and restarts the clear window
      if (abort) begin
         state_d    = CLEAR;
         clr_cnt_d  = '0;
         info_vld_d = 1'b0;
         par_vld_d  = 1'b0;
         sop_d      = 1'b0;
         last_d     = 1'b0;
      end

      if (state_d == CLEAR) begin
         cnt_d  = '0;
         addr_d = ADDR_TOP;
      end

      in_ready_d = (state_d == LOAD);
      enc_run_d  = (state_d != CLEAR);
      check_d    = (state_d == PARITY);
      busy_d     = (state_d != CLEAR);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= '0;
         cnt_q      <= '0;
         addr_q     <= ADDR_TOP;
         in_ready_q <= 1'b0;
         enc_run_q  <= 1'b0;
         check_q    <= 1'b0;
         busy_q     <= 1'b0;
         info_vld_q <= 1'b0;
         info_bit_q <= 1'b0;
         par_vld_q  <= 1'b0;
         sop_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
         enc_run_q  <= enc_run_d;
         check_q    <= check_d;
         busy_q     <= busy_d;
         info_vld_q <= info_vld_d;
         info_bit_q <= info_bit_d;
         par_vld_q  <= par_vld_d;
         sop_q      <= sop_d;
         last_q     <= last_d;
      end
   end

   // Encoder clear follows rst_n directly so a mid-frame reset clears it at once
   assign enc_rst_n     = rst_n & enc_run_q;
   assign in_ready      = in_ready_q;
   assign enc_din_valid = hs;
   assign enc_din       = in_bit & in_ready_q;
   assign enc_counter   = cnt_q;
   assign enc_out_addr  = addr_q;
   assign enc_check     = check_q;
   assign busy          = busy_q;
   assign out_valid     = info_vld_q | par_vld_q;
   // Encoder output is already registered; the parity bit passes straight through
   assign out_bit       = par_vld_q ? enc_dout : info_bit_q;
   assign out_sop       = sop_q;
   assign out_last      = last_q;

endmodule

// File: doc/ldpc_enc_ctrl.md
Name: ldpc_enc_ctrl

Overview:
- Frame sequencer for the 360-bit-parallel LDPC parity encoder: accepts a K_BITS information-bit stream over a valid/ready handshake and drives the encoder's clear, din_valid/din, bit counter, parity read address and output-enable.
- Collects the registered parity bits and emits the codeword as one serial output stream.
- Sits between the scrambler/bit source and the bit interleaver; the encoder is instantiated alongside it at the parent level.

Parameters:
- K_BITS, 4320, information bits per frame (12 groups of GROUP).
- GROUP, 360, parallelism / parity bits per frame.
- CNT_W, 13, width of enc_counter.
- ADDR_W, 9, width of enc_out_addr.
- CLR_CYC, 3, cycles the encoder is held in clear before a frame (covers ROM prefetch of group 0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  information bit valid.
- in_bit  in  1  information bit.
- in_ready  out  1  controller accepts in_bit this cycle.
- abort  in  1  synchronous frame abort.
- enc_rst_n  out  1  encoder clear, active-low.
- enc_din_valid  out  1  to encoder din_valid.
- enc_din  out  1  to encoder din.
- enc_counter  out  CNT_W  index of the bit on enc_din.
- enc_out_addr  out  ADDR_W  parity bit select.
- enc_check  out  1  to encoder data_valid_check.
- enc_dout  in  1  encoder parity output; 1-cycle latency from enc_out_addr.
- out_valid  out  1  output bit valid.
- out_bit  out  1  codeword bit.
- out_sop  out  1  first bit of codeword.
- out_last  out  1  last parity bit of codeword.
- busy  out  1  high outside CLEAR.

Behaviour:
Reset:
- Rising from reset, the FSM is in CLEAR with a clear count of 0.
- enc_rst_n = 0; enc_counter = 0; enc_out_addr = GROUP-1.
- All other outputs = 0.

States:
- CLEAR:
  - enc_rst_n = 0, enc_counter = 0, in_ready = 0.
  - After CLR_CYC cycles -> LOAD.
- LOAD:
  - in_ready = 1.
  - enc_din_valid = in_valid, enc_din = in_bit.
  - enc_counter = index of the current bit (0..K_BITS-1).
  - The counter increments only on a handshake (in_valid & in_ready); idle cycles hold it.
  - On the handshake of bit K_BITS-1 -> SETTLE. enc_counter holds K_BITS-1, and in_ready drops in the next cycle.
- SETTLE:
  - One cycle, enc_din_valid = 0, so the final XOR lands in the accumulator.
  - -> PARITY.
- PARITY:
  - enc_check = 1.
  - enc_out_addr counts GROUP-1 down to 0, one per cycle.
  - After addr 0 is issued -> TAIL.
- TAIL:
  - One cycle, capturing the last enc_dout.
  - -> CLEAR.

Output timing (uniform 1-cycle latency):
- Information bit accepted in cycle t appears on out_bit at t+1.
- Parity address issued in cycle t yields out_bit = enc_dout at t+1.
- Parity order is address GROUP-1 first.
- out_sop is on bit 0; out_last is on the parity bit from address 0.
- No output backpressure. Downstream must sink one bit per cycle.

Abort:
- Any state -> CLEAR next cycle; the clear count restarts.
- A pending output bit is dropped: out_valid = 0 the cycle after abort.
- Abort during CLEAR restarts the clear count.
- Abort has priority over a simultaneous final-bit handshake.

Reset mid-frame:
- Identical to the power-up reset state. The encoder also sees enc_rst_n = 0 immediately.

Frame gap:
- Back-to-back frames are separated by 1 (SETTLE) + GROUP + 1 (TAIL) + CLR_CYC cycles with in_ready = 0.

Optional Feature:
- LDPC_ENC_CTRL_SYS_EN defined: systematic output.
  - Information bits are echoed (K_BITS+GROUP = 4680 bits per frame).
  - out_sop is on info bit 0.
- Not defined: information bits are not echoed.
  - out_valid is only asserted for parity bits (GROUP per frame).
  - out_sop is on the first parity bit.

Decomposition:
- Package ldpc_enc_pkg holds:
  - State enum (CLEAR, LOAD, SETTLE, PARITY, TAIL).
  - Constants K_BITS = 4320, GROUP = 360, N_GROUPS = 12, CNT_W, ADDR_W.
- No sub-module: the FSM, bit counter and address down-counter are one block. The encoder is wired at the parent.

Test Plan:
- Reset, then 4320 bits all 0 with in_valid = 1 continuously:
  - CLEAR lasts 3 cycles.
  - enc_counter runs 0..4319.
  - Parity addresses run 359..0 with enc_check = 1.
  - 360 parity bits = 0, out_last on the 360th.
- Single 1 at bit index 0, then at index 359, then at 360 (three frames):
  - Parity matches the golden model (encoder + ROM).
  - enc_counter reads 359 and 360 on the respective handshakes.
- in_valid toggled 1010... for a full frame:
  - enc_counter advances only on handshakes.
  - Total accepted = 4320.
  - SETTLE is entered exactly once.
- abort pulsed when enc_counter = 2000:
  - Next cycle: CLEAR, in_ready = 0, enc_rst_n = 0 for 3 cycles.
  - The following clean frame matches the golden model.
- Two back-to-back random frames, SYS_EN defined:
  - 4680 output bits each, one out_sop and one out_last each.
  - Gap between frames = 1+360+1+3 cycles.
- rst_n low for 1 cycle mid-PARITY (address 100):
  - out_valid = 0 and enc_check = 0 next cycle.
  - The FSM restarts in CLEAR.
